// File: rtl/elelock_pkg.sv
// Shared types and helpers for the elelock_code keypad lock.
//   state_e  : controller states
//   onehot10 : 1 when exactly one of the ten key lines is set
//   keyenc   : one-hot key pattern to digit 0..9, 4'hF for any other pattern
package elelock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    ENTRY,
    OPEN,
    LOCKOUT
  } state_e;

  function automatic logic onehot10(input logic [9:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return (cnt == 4'd1);
  endfunction

  function automatic logic [3:0] keyenc(input logic [9:0] v);
    logic [3:0] k;
    k = 4'hF;
    if (onehot10(v)) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (v[i]) k = 4'(i);
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/tenkey_scan.sv
// Key pad front end: registers the raw pad every cycle and flags a new
// single-key press that follows a full release.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   tenkey_i  : raw pad, bit k = key k pressed
//   accept_o  : one-cycle pulse, new valid press (combinational)
//   digit_o   : encoded digit of tenkey_i (combinational)
module tenkey_scan
  import elelock_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] tenkey_i,
  output logic       accept_o,
  output logic [3:0] digit_o
);

  logic [9:0] tk_q;

  // tk_q follows the pad in every controller state, so a key held across a
  // state change is not seen as a fresh press; any nonzero pattern
  // (including multi-key) blocks acceptance until the pad is fully released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tk_q <= '0;
    else         tk_q <= tenkey_i;
  end

  always_comb begin
    accept_o = onehot10(tenkey_i) && (tk_q == '0);
    digit_o  = keyenc(tenkey_i);
  end

endmodule

// File: rtl/elelock_code.sv
// Multi-digit keypad lock controller.
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   tenkey     : raw 10-key pad
//   close      : relock request (level)
//   lock       : 1 = bolt engaged
//   lockout    : 1 = lockout in progress, keys ignored
//   digit_cnt  : digits accepted in the current entry
//   fail_cnt   : consecutive failed attempts
module elelock_code
  import elelock_pkg::*;
#(
  parameter int unsigned              DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]      SECRET      = 16'h1234,
  parameter int unsigned              MAX_FAIL    = 3,
  parameter int unsigned              LOCKOUT_CYC = 1000,
  parameter int unsigned              ENTRY_TMO   = 5000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [9:0]                         tenkey,
  input  logic                               close,
  output logic                               lock,
  output logic                               lockout,
  output logic [$clog2(DIGITS+1)-1:0]        digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

  localparam int unsigned EW = 4 * DIGITS;
  localparam int unsigned DW = $clog2(DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int unsigned IW = $clog2(ENTRY_TMO + 1);

  logic       accept;
  logic [3:0] digit;

  tenkey_scan u_scan (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .tenkey_i (tenkey),
    .accept_o (accept),
    .digit_o  (digit)
  );

  state_e         state_q, state_d;
  logic [EW-1:0]  entry_q, entry_d;
  logic [DW-1:0]  dcnt_q,  dcnt_d;
  logic [FW-1:0]  fcnt_q,  fcnt_d;
  logic [LW-1:0]  ltmr_q,  ltmr_d;
  logic [IW-1:0]  itmr_q,  itmr_d;
  logic           lock_q,  lock_d;
  logic           lkout_q, lkout_d;

  logic [EW-1:0]  shifted;
  logic           take;
  logic           last_digit;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    dcnt_d  = dcnt_q;
    fcnt_d  = fcnt_q;
    ltmr_d  = ltmr_q;
    itmr_d  = itmr_q;

    // Cast drops the oldest nibble; also valid for a single-digit code.
    shifted    = EW'({entry_q, digit});
    last_digit = (dcnt_q == DW'(DIGITS - 1));
    take       = 1'b0;

    unique case (state_q)
      LOCKED: begin
        take = accept;
      end
      ENTRY: begin
        if (close) begin
          state_d = LOCKED;
          entry_d = '0;
          dcnt_d  = '0;
          itmr_d  = '0;
        end else if (accept) begin
          take = 1'b1;
        end else if (itmr_q == IW'(ENTRY_TMO - 1)) begin
          state_d = LOCKED;
          entry_d = '0;
          dcnt_d  = '0;
          itmr_d  = '0;
        end else begin
          itmr_d = itmr_q + IW'(1);
        end
      end
      OPEN: begin
        if (close) state_d = LOCKED;
      end
      LOCKOUT: begin
        if (ltmr_q == '0) begin
          state_d = LOCKED;
          fcnt_d  = '0;
        end else begin
          ltmr_d = ltmr_q - LW'(1);
        end
      end
      default: state_d = LOCKED;
    endcase

    // LOCKED and ENTRY share digit intake so a one-digit code is judged on
    // the very first press.
    if (take) begin
      itmr_d = '0;
      if (last_digit) begin
        entry_d = '0;
        dcnt_d  = '0;
        if (shifted == SECRET) begin
          state_d = OPEN;
          fcnt_d  = '0;
        end else if (fcnt_q == FW'(MAX_FAIL - 1)) begin
          state_d = LOCKOUT;
          fcnt_d  = FW'(MAX_FAIL);
          ltmr_d  = LW'(LOCKOUT_CYC - 1);
        end else begin
          state_d = LOCKED;
          fcnt_d  = fcnt_q + FW'(1);
        end
      end else begin
        state_d = ENTRY;
        entry_d = shifted;
        dcnt_d  = dcnt_q + DW'(1);
      end
    end

    lock_d  = (state_d != OPEN);
    lkout_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCKED;
      entry_q <= '0;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
      ltmr_q  <= '0;
      itmr_q  <= '0;
      lock_q  <= 1'b1;
      lkout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
      ltmr_q  <= ltmr_d;
      itmr_q  <= itmr_d;
      lock_q  <= lock_d;
      lkout_q <= lkout_d;
    end
  end

  assign lock      = lock_q;
  assign lockout   = lkout_q;
  assign digit_cnt = dcnt_q;
  assign fail_cnt  = fcnt_q;

endmodule
